// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART bit-clock generator.
//   - baud_sel_t   : 3-bit rate select code
//   - chan_state_t : per-channel generator state
//   - baud_rate()  : rate select code -> baud rate in bit/s
//   - calc_div()   : system clock / baud rate divisor, rounded and clamped
package uart_pkg;

  typedef logic [2:0] baud_sel_t;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_LOW  = 2'd1,
    CH_HIGH = 2'd2
  } chan_state_t;

  // Fixed baud table; code 0 is the slowest rate and so gives the largest divisor.
  function automatic int unsigned baud_rate(input baud_sel_t sel);
    int unsigned rate;
    case (sel)
      3'd0:    rate = 32'd9600;
      3'd1:    rate = 32'd19200;
      3'd2:    rate = 32'd38400;
      3'd3:    rate = 32'd57600;
      3'd4:    rate = 32'd115200;
      3'd5:    rate = 32'd230400;
      3'd6:    rate = 32'd460800;
      3'd7:    rate = 32'd921600;
      default: rate = 32'd9600;
    endcase
    return rate;
  endfunction

  // Divisor rounded to nearest and never below min_div, so LOW and HIGH
  // phases are always at least one clock long.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned min_div,
                                           input baud_sel_t   sel);
    int unsigned rate;
    int unsigned div;
    rate = baud_rate(sel);
    div  = (clk_freq + (rate / 32'd2)) / rate;
    if (div < min_div) begin
      div = min_div;
    end else begin
      div = div;
    end
    return div;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: connection between the UART transceiver and its bit-clock
// generator.
//   baud_sel                 : rate select (transceiver -> generator)
//   en_tx / en_rx            : channel enables (transceiver -> generator)
//   clk_uart_tx / clk_uart_rx: bit clocks (generator -> transceiver)
//   busy_tx / busy_rx        : channel active flags (generator -> transceiver)
// master = transceiver side, slave = generator side.
interface uart_baud_gen_if;
  import uart_pkg::*;

  baud_sel_t baud_sel;
  logic      en_tx;
  logic      en_rx;
  logic      clk_uart_tx;
  logic      clk_uart_rx;
  logic      busy_tx;
  logic      busy_rx;

  modport master (
    output baud_sel, en_tx, en_rx,
    input  clk_uart_tx, clk_uart_rx, busy_tx, busy_rx
  );

  modport slave (
    input  baud_sel, en_tx, en_rx,
    output clk_uart_tx, clk_uart_rx, busy_tx, busy_rx
  );
endinterface

// File: rtl/uart_baud_chan.sv
// uart_baud_chan: one gated bit-clock channel.
//   clk, rst : system clock, asynchronous active-high reset
//   en       : channel enable from the transceiver
//   lo, hi   : LOW / HIGH phase lengths in clk cycles, latched at start
//   clk_uart : bit clock; negedge at bit boundary, posedge mid-bit
//   busy     : channel is generating (not IDLE)
module uart_baud_chan
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W = 32'd14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] lo,
  input  logic [CNT_W-1:0] hi,
  output logic             clk_uart,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  chan_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] lo_r;
  logic [CNT_W-1:0] hi_r;
  logic             clk_uart_r;
  logic             busy_r;

  assign clk_uart = clk_uart_r;
  assign busy     = busy_r;

  // Phase sequencer: IDLE -> LOW -> HIGH -> LOW ...; a LOW phase always runs
  // to completion so the bit clock never produces a short pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= CH_IDLE;
      cnt_r      <= CNT_ZERO;
      lo_r       <= CNT_ZERO;
      hi_r       <= CNT_ZERO;
      clk_uart_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        CH_IDLE: begin
          cnt_r <= CNT_ZERO;
          if (en) begin
            // Rate is frozen here; later baud_sel changes wait for the next start.
            lo_r       <= lo;
            hi_r       <= hi;
            clk_uart_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= CH_LOW;
          end else begin
            clk_uart_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= CH_IDLE;
          end
        end
        CH_LOW: begin
          if (cnt_r == (lo_r - CNT_ONE)) begin
            clk_uart_r <= 1'b1;
            cnt_r      <= CNT_ZERO;
            if (en) begin
              busy_r  <= 1'b1;
              state_r <= CH_HIGH;
            end else begin
              busy_r  <= 1'b0;
              state_r <= CH_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        CH_HIGH: begin
          if (!en) begin
            // Output is already high, so stopping here adds no edge.
            clk_uart_r <= 1'b1;
            cnt_r      <= CNT_ZERO;
            busy_r     <= 1'b0;
            state_r    <= CH_IDLE;
          end else if (cnt_r == (hi_r - CNT_ONE)) begin
            clk_uart_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
            state_r    <= CH_LOW;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          clk_uart_r <= 1'b1;
          cnt_r      <= CNT_ZERO;
          busy_r     <= 1'b0;
          state_r    <= CH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: TX/RX bit-clock generator for the UART transceiver.
//   clk, rst : system clock (CLK_FREQ Hz), asynchronous active-high reset
//   bus      : uart_baud_gen_if.slave
//                baud_sel -> rate table index
//                en_tx/en_rx -> start/stop each channel
//                clk_uart_tx/clk_uart_rx, busy_tx/busy_rx <- registered outputs
// Both channels share the rate decode but are otherwise independent.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 32'd100_000_000,
  parameter int unsigned MIN_DIV  = 32'd2
) (
  input  logic            clk,
  input  logic            rst,
  uart_baud_gen_if.slave  bus
);

  // Slowest rate gives the largest divisor and so sets the counter width.
  localparam int unsigned MAX_DIV = calc_div(CLK_FREQ, MIN_DIV, 3'd0);
  localparam int unsigned CNT_W   = (MAX_DIV > 32'd2) ? $clog2(MAX_DIV) : 32'd1;

  logic [31:0]      div_s;
  logic [CNT_W-1:0] lo_s;
  logic [CNT_W-1:0] hi_s;

  // Rate decode: every table entry is a constant, so this reduces to a mux.
  always_comb begin
    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd0);
    case (bus.baud_sel)
      3'd0:    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd0);
      3'd1:    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd1);
      3'd2:    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd2);
      3'd3:    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd3);
      3'd4:    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd4);
      3'd5:    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd5);
      3'd6:    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd6);
      3'd7:    div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd7);
      default: div_s = calc_div(CLK_FREQ, MIN_DIV, 3'd0);
    endcase
  end

  // Odd divisors put the extra clock in HIGH so the posedge stays at mid-bit.
  assign lo_s = CNT_W'(div_s >> 1);
  assign hi_s = CNT_W'(div_s - (div_s >> 1));

  uart_baud_chan #(
    .CNT_W (CNT_W)
  ) u_chan_tx (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en_tx),
    .lo       (lo_s),
    .hi       (hi_s),
    .clk_uart (bus.clk_uart_tx),
    .busy     (bus.busy_tx)
  );

  uart_baud_chan #(
    .CNT_W (CNT_W)
  ) u_chan_rx (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en_rx),
    .lo       (lo_s),
    .hi       (hi_s),
    .clk_uart (bus.clk_uart_rx),
    .busy     (bus.busy_rx)
  );

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: scoreboard bench for uart_baud_gen.
// Each channel run pushes its expected (cycle, clk_uart, busy) change events
// into a per-channel queue; a monitor pops one event for every observed output
// change and compares it.
module tb_uart_baud_gen;
  import uart_pkg::*;

  typedef struct {
    int   cyc;
    logic ck;
    logic bz;
  } ev_t;

  // Hand-computed divisors at 100 MHz for baud_sel 0..7.
  localparam int DIV_TBL [8] = '{10417, 5208, 2604, 1736, 868, 434, 217, 109};

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;
  ev_t  q_tx[$];
  ev_t  q_rx[$];

  uart_baud_gen_if bus();

  uart_baud_gen #(
    .CLK_FREQ (100_000_000),
    .MIN_DIV  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input int ch, input int c, input logic ck, input logic bz);
    ev_t e;
    e.cyc = c;
    e.ck  = ck;
    e.bz  = bz;
    if (ch == 0) q_tx.push_back(e);
    else         q_rx.push_back(e);
  endtask

  task automatic set_en(input int ch, input logic v);
    if (ch == 0) bus.en_tx = v;
    else         bus.en_rx = v;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling clk edge, one comparison per output change.
  task automatic monitor_loop();
    logic pc [2];
    logic pb [2];
    logic cc, cb;
    ev_t  e;
    bit   have;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        cc = (ch == 0) ? bus.clk_uart_tx : bus.clk_uart_rx;
        cb = (ch == 0) ? bus.busy_tx : bus.busy_rx;
        if (mon_en && ((cc !== pc[ch]) || (cb !== pb[ch]))) begin
          checks++;
          have = 1'b1;
          if (ch == 0) begin
            if (q_tx.size() == 0) have = 1'b0;
            else e = q_tx.pop_front();
          end else begin
            if (q_rx.size() == 0) have = 1'b0;
            else e = q_rx.pop_front();
          end
          if (!have) begin
            errors++;
            $display("FAIL ev_ch%0d unexpected change: cyc=%0d clk=%b busy=%b, expected no change",
                     ch, cyc, cc, cb);
          end else if ((e.cyc != cyc) || (e.ck !== cc) || (e.bz !== cb)) begin
            errors++;
            $display("FAIL ev_ch%0d: got cyc=%0d clk=%b busy=%b, expected cyc=%0d clk=%b busy=%b",
                     ch, cyc, cc, cb, e.cyc, e.ck, e.bz);
          end
        end
        pc[ch] = cc;
        pb[ch] = cb;
      end
    end
  endtask

  // One channel run: start at the current falling edge, generate nper periods,
  // then drop en either 'off' clks into the last LOW phase (drop_low) or 'off'
  // clks after the last rising edge. Returns once the channel is back in IDLE.
  task automatic run(input int ch, input int sel, input int nper,
                     input bit drop_low, input int off);
    int c, d, lo, s, base, rise, x, end_c;
    c  = cyc;
    d  = DIV_TBL[sel];
    lo = d / 2;
    s  = c + 1;
    x  = c;
    end_c = c;
    bus.baud_sel = 3'(sel);
    set_en(ch, 1'b1);
    push(ch, s, 1'b0, 1'b1);
    for (int k = 0; k < nper; k++) begin
      base = s + k * d;
      rise = base + lo;
      if (k == nper - 1) begin
        if (drop_low) begin
          x = base + off;
          push(ch, rise, 1'b1, 1'b0);
          end_c = rise;
        end else begin
          push(ch, rise, 1'b1, 1'b1);
          x = rise + off;
          push(ch, x + 1, 1'b1, 1'b0);
          end_c = x + 1;
        end
      end else begin
        push(ch, rise, 1'b1, 1'b1);
        push(ch, base + d, 1'b0, 1'b1);
      end
    end
    wait_until(x);
    set_en(ch, 1'b0);
    wait_until(end_c);
  endtask

  initial begin
    int c;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    bus.baud_sel = 3'd0;
    bus.en_tx    = 1'b0;
    bus.en_rx    = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("reset_clk_tx", bus.clk_uart_tx, 1'b1);
    chk("reset_busy_tx", bus.busy_tx, 1'b0);
    chk("reset_clk_rx", bus.clk_uart_rx, 1'b1);
    chk("reset_busy_rx", bus.busy_rx, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);

    // 115200: DIV 868, 434/434.
    run(0, 4, 2, 1'b0, 100);
    repeat (5) @(negedge clk);

    // 921600: odd DIV 109, 54/55, ten periods.
    run(0, 7, 10, 1'b0, 2);
    repeat (5) @(negedge clk);

    // RX at 230400, en dropped 10 clks into LOW; LOW completes at 217.
    run(1, 5, 1, 1'b1, 10);
    repeat (300) @(negedge clk);

    // Drop mid-HIGH, then restart immediately with a new rate.
    run(0, 4, 1, 1'b0, 50);
    run(0, 7, 1, 1'b0, 3);
    repeat (5) @(negedge clk);

    // baud_sel changed while busy is ignored; next start uses 9600.
    fork
      run(0, 4, 3, 1'b0, 10);
      begin
        repeat (900) @(negedge clk);
        bus.baud_sel = 3'd0;
      end
    join
    run(0, 0, 1, 1'b0, 0);
    repeat (5) @(negedge clk);

    // Both channels together, 100 clks apart at different rates.
    fork
      run(0, 6, 4, 1'b0, 5);
      begin
        repeat (100) @(negedge clk);
        run(1, 7, 5, 1'b0, 3);
      end
    join
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-LOW.
    c = cyc;
    bus.baud_sel = 3'd4;
    bus.en_tx = 1'b1;
    bus.en_rx = 1'b1;
    push(0, c + 1, 1'b0, 1'b1);
    push(1, c + 1, 1'b0, 1'b1);
    wait_until(c + 20);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_clk_tx", bus.clk_uart_tx, 1'b1);
    chk("async_rst_busy_tx", bus.busy_tx, 1'b0);
    chk("async_rst_clk_rx", bus.clk_uart_rx, 1'b1);
    chk("async_rst_busy_rx", bus.busy_rx, 1'b0);
    bus.en_tx = 1'b0;
    bus.en_rx = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    repeat (20) @(negedge clk);

    // Every expected event must have been seen.
    checks++;
    if (q_tx.size() != 0) begin
      errors++;
      $display("FAIL pending_tx: got %0d unseen events, expected 0", q_tx.size());
    end
    checks++;
    if (q_rx.size() != 0) begin
      errors++;
      $display("FAIL pending_rx: got %0d unseen events, expected 0", q_rx.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Bit-clock generator that drives the clk_uart_tx / clk_uart_rx inputs of the UART transceiver.
- Responds to its uart_enable_tx / uart_enable_rx outputs.
- Produces a gated, phase-aligned square wave per direction:
  - negedge at each bit boundary, where the UART state machines advance;
  - posedge at mid-bit, where RX samples.
- Runs entirely in the clk domain. Baud rate is selected at runtime from a fixed table.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- MIN_DIV, 2, lower clamp on any computed divisor.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- baud_sel  in  3  rate select: 0:9600 1:19200 2:38400 3:57600 4:115200 5:230400 6:460800 7:921600.
- en_tx  in  1  enable from transceiver uart_enable_tx.
- en_rx  in  1  enable from transceiver uart_enable_rx.
- clk_uart_tx  out  1  TX bit clock.
- clk_uart_rx  out  1  RX bit clock.
- busy_tx  out  1  TX channel generating (not IDLE).
- busy_rx  out  1  RX channel generating (not IDLE).

Behaviour:
- Two identical, independent channels (tx, rx). All logic is on posedge clk. All outputs are registered.
- Reset state, per channel:
  - clk_uart = 1, busy = 0, state IDLE, counter 0, latched divisor 0.
- Divisor rule:
  - DIV = (CLK_FREQ + baud/2) / baud, integer, rounded to nearest; clamped to at least MIN_DIV.
  - LO = DIV/2 (floor), HI = DIV - LO.
  - Counter width = clog2 of the largest DIV (at 9600).
- States: IDLE, LOW, HIGH.
- IDLE:
  - clk_uart held 1.
  - On the first posedge with en=1: latch LO/HI from baud_sel, set clk_uart<=0, counter<=0, busy<=1, go to LOW.
  - The first negedge therefore appears 1 clk after en is seen high.
- LOW:
  - Counter increments each clk.
  - When counter == LO-1: clk_uart<=1, counter<=0, go to HIGH.
  - If en=0 at that point: go to IDLE instead (clk_uart<=1, busy<=0).
  - A LOW phase always completes; the output never glitches.
- HIGH:
  - When counter == HI-1: if en=1, clk_uart<=0, counter<=0, go to LOW; else go to IDLE.
  - If en drops mid-HIGH: go to IDLE on the next clk. clk_uart stays 1, so no extra edge is produced.
- Resulting timing: posedge lands LO clks after each negedge (mid-bit); the bit period is DIV clks.
- baud_sel is sampled only on IDLE->LOW. Changes while busy are ignored until the next start.
- en re-asserted in the same clk that IDLE is entered: taken on the next clk (one full IDLE cycle minimum).
- Both channels may run simultaneously with different start times. They share the lookup table but nothing else.
- rst asserted mid-operation: immediately clk_uart=1, busy=0, IDLE; a posedge may occur on clk_uart (acceptable because the transceiver is in reset too).

Decomposition:
- Package uart_pkg:
  - baud table constants;
  - a divisor function (CLK_FREQ, sel) -> DIV with rounding and clamp;
  - channel state encoding.
- Sub-module uart_baud_chan (one channel: en, lo, hi -> clk_uart, busy), instantiated twice.
- The top level holds the shared baud_sel -> LO/HI decode.

Test Plan:
- Default params, baud_sel=4, pulse en_tx high:
  - DIV=868; clk_uart_tx falls 1 clk after en, low 434 clks, high 434 clks;
  - busy_tx=1 within 1 clk; period exactly 868 clks.
- baud_sel=7 (odd divisor):
  - DIV=109; each period low 54 / high 55 clks;
  - hold en 10 periods -> exactly 10 negedges, spacing 109.
- Drop en_rx 10 clks into a LOW phase (baud_sel=5, DIV=434, LO=217):
  - clk_uart_rx stays low until clk 217, rises, then stays 1;
  - busy_rx=0 on the same edge; no further edges.
- Drop en mid-HIGH:
  - output stays 1, busy=0 next clk;
  - re-assert en -> new negedge exactly 1 clk later, with the new baud_sel applied.
- Change baud_sel 4->0 while busy_tx:
  - period stays 868 until en drops;
  - next start gives DIV=10417 (LO 5208, HI 5209).
- Both channels, plus async rst:
  - start en_tx and en_rx 100 clks apart at different rates; verify independent periods;
  - assert rst mid-LOW -> both clk_uart=1 and busy=0 without waiting for clk.
